people_move_control: RTL and testbench
======================================

// Module: people_move_control
// PURPOSE
//  Player ("people") position controller; the producer side of the ghost interface.
//  Drives people_up/people_left into every ghost controller and consumes their
//  OR-ed fail flag. Moves the sprite from level-sensitive key inputs on a slow tick.
//  Handles hit/respawn and lives for the active stage, and feeds the VGA sprite mux.
// PARAMETERS
//  ACTIVE_STAGE  5           stage_state value in which the player may move
//  TICK_DIV      10_000_000  clk cycles per movement tick
//  STEP          3           pixels moved per tick
//  SPAWN_UP      330         spawn row (sprite top)
//  SPAWN_LEFT    100         spawn column (sprite left)
//  UP_MIN/UP_MAX 65/400      clamp range for people_up
//  LEFT_MIN/LEFT_MAX 40/560  clamp range for people_left
//  LIVES         3           lives at stage entry (1..3)
//  HIT_TICKS     10          freeze length after a hit, in ticks
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  stage_state  in   3   global stage FSM state
//  key_up       in   1   level, held key (from keyboard decoder)
//  key_down     in   1   level
//  key_left     in   1   level
//  key_right    in   1   level
//  fail         in   1   OR of ghost fail outputs (sticky on the ghost side)
//  people_up    out  10  sprite top row
//  people_left  out  10  sprite left column
//  dir          out  2   facing: LEFT=0 RIGHT=1 UP=2 DOWN=3
//  visible      out  1   sprite draw enable (blinks during HIT)
//  lives        out  2   remaining lives
//  game_over    out  1   lives exhausted
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, people_up=SPAWN_UP, people_left=SPAWN_LEFT,
//   dir=RIGHT, visible=1, lives=LIVES, game_over=0, tick counter=0, fail_d=0.
//  Tick: counter counts 0..TICK_DIV-1 while stage_state==ACTIVE_STAGE; at TICK_DIV-1
//   wraps to 0 and pulses tick for 1 cycle; forced to 0 (no tick) otherwise.
//  FSM: IDLE -> PLAY when stage_state==ACTIVE_STAGE.
//   PLAY: on tick, apply movement. hit = fail & ~fail_d (rising edge, fail_d registered).
//   PLAY --hit, lives>1--> HIT: lives-1, position := spawn, dir=RIGHT, hold=HIT_TICKS.
//   PLAY --hit, lives==1--> DEAD: lives=0, game_over=1, position frozen, visible=1.
//   HIT: no movement; visible toggles each tick; hold-1 per tick; at 0 -> PLAY, visible=1.
//   DEAD: absorbing until stage exit or reset.
//   Any state, stage_state!=ACTIVE_STAGE -> IDLE next cycle: spawn position, dir=RIGHT,
//    lives=LIVES, game_over=0, visible=1. Stage exit wins over a same-cycle hit.
//  Movement (per tick, PLAY only): vertical UP>DOWN, horizontal LEFT>RIGHT;
//   up&down both held -> no vertical; left&right both held -> no horizontal.
//   One axis per tick: vertical takes priority over horizontal.
//   Math in 11 bits; UP: max(people_up-STEP, UP_MIN); DOWN: min(people_up+STEP, UP_MAX);
//   same for left with LEFT_MIN/LEFT_MAX. No wrap-around at 0 or 1023.
//   dir updates to the moved direction, even when clamped; unchanged if no key.
//  Key inputs and fail are synchronous to clk; no internal debounce.
//  Latency: position updates the cycle after tick; hit takes effect the cycle after
//   fail rises.
// CONFIGURATION
//  PEOPLE_DIAG_EN defined: vertical and horizontal moves both applied on the same tick
//   (diagonal); dir reports the vertical direction when both axes move.
//  Undefined: one axis per tick as above.
// TESTING (TICK_DIV=4 in sim)
//  rst_n low mid-move -> outputs at reset values same cycle, before any clk edge.
//  stage=5, key_up held from people_up=330 -> 327,324,... one step per 4 clks, stops at 65.
//  key_left held from people_left=42 -> 40 then holds at 40; dir=0; key_up+key_down -> no move.
//  fail 0->1 in PLAY, lives=3 -> lives=2, pos=(330,100), visible toggles 10 ticks, no move.
//  Three fail edges (fail dropped between) -> lives=0, game_over=1; stage=2 -> lives=3, game_over=0.
//  PEOPLE_DIAG_EN, key_up+key_right from (330,100) -> (327,103), dir=2; without -> (327,100).

Source files
------------

// File: rtl/people_move_control.sv
`default_nettype none
// ============================================================================
//  Module   : people_move_control
//  Purpose  : Player sprite position, facing, hit/respawn and lives control,
//             stepped on a slow movement tick while the play stage is active.
//             Define PEOPLE_DIAG_EN to apply vertical and horizontal moves on
//             the same tick (diagonal movement).
//  Revision : 1.0  initial release
// ============================================================================
module people_move_control #(
  parameter int ACTIVE_STAGE = 5,
  parameter int TICK_DIV     = 10_000_000,
  parameter int STEP         = 3,
  parameter int SPAWN_UP     = 330,
  parameter int SPAWN_LEFT   = 100,
  parameter int UP_MIN       = 65,
  parameter int UP_MAX       = 400,
  parameter int LEFT_MIN     = 40,
  parameter int LEFT_MAX     = 560,
  parameter int LIVES        = 3,
  parameter int HIT_TICKS    = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] stage_state,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       fail,
  output logic [9:0] people_up,
  output logic [9:0] people_left,
  output logic [1:0] dir,
  output logic       visible,
  output logic [1:0] lives,
  output logic       game_over
);

  localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HOLD_W = $clog2(HIT_TICKS + 1);

  localparam logic [1:0] c_dir_left  = 2'd0;
  localparam logic [1:0] c_dir_right = 2'd1;
  localparam logic [1:0] c_dir_up    = 2'd2;
  localparam logic [1:0] c_dir_down  = 2'd3;

`ifdef PEOPLE_DIAG_EN
  localparam logic c_diag = 1'b1;
`else
  localparam logic c_diag = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HIT  = 2'd2,
    DEAD = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_tick_cnt;
  logic              r_fail_d;
  logic [HOLD_W-1:0] r_hold, w_hold_nxt;

  logic [9:0] w_up_nxt, w_left_nxt;
  logic [1:0] w_dir_nxt, w_lives_nxt;
  logic       w_vis_nxt, w_go_nxt;

  logic w_stage_act, w_tick, w_hit;

  assign w_stage_act = (stage_state == 3'(ACTIVE_STAGE));
  assign w_tick      = w_stage_act && (r_tick_cnt == CNT_W'(TICK_DIV - 1));
  assign w_hit       = fail & ~r_fail_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
      r_fail_d   <= 1'b0;
    end else begin
      r_fail_d <= fail;
      if (!w_stage_act || w_tick) r_tick_cnt <= '0;
      else                        r_tick_cnt <= r_tick_cnt + CNT_W'(1);
    end
  end

  // Clamped one-step candidates; sums carry an 11th bit so nothing wraps at 1023.
  logic [10:0] w_up_sum, w_left_sum;
  logic [9:0]  w_up_dec, w_up_inc, w_left_dec, w_left_inc;

  assign w_up_sum   = {1'b0, people_up} + 11'(STEP);
  assign w_left_sum = {1'b0, people_left} + 11'(STEP);
  assign w_up_dec   = (people_up < 10'(UP_MIN + STEP)) ? 10'(UP_MIN) : people_up - 10'(STEP);
  assign w_up_inc   = (w_up_sum > 11'(UP_MAX)) ? 10'(UP_MAX) : w_up_sum[9:0];
  assign w_left_dec = (people_left < 10'(LEFT_MIN + STEP)) ? 10'(LEFT_MIN) : people_left - 10'(STEP);
  assign w_left_inc = (w_left_sum > 11'(LEFT_MAX)) ? 10'(LEFT_MAX) : w_left_sum[9:0];

  logic       w_do_v, w_do_h;
  logic [9:0] w_up_moved, w_left_moved;
  logic [1:0] w_dir_moved;

  // Opposing keys cancel on their axis; vertical wins unless diagonal moves are on.
  assign w_do_v = key_up ^ key_down;
  assign w_do_h = (key_left ^ key_right) & (c_diag | ~w_do_v);

  assign w_up_moved   = w_do_v ? (key_up ? w_up_dec : w_up_inc) : people_up;
  assign w_left_moved = w_do_h ? (key_left ? w_left_dec : w_left_inc) : people_left;
  assign w_dir_moved  = w_do_v ? (key_up ? c_dir_up : c_dir_down)
                      : w_do_h ? (key_left ? c_dir_left : c_dir_right)
                      : dir;

  always_comb begin
    w_state_nxt = r_state;
    w_up_nxt    = people_up;
    w_left_nxt  = people_left;
    w_dir_nxt   = dir;
    w_vis_nxt   = visible;
    w_lives_nxt = lives;
    w_go_nxt    = game_over;
    w_hold_nxt  = r_hold;

    if (!w_stage_act) begin
      // Leaving the stage restores the entry conditions and outranks any hit.
      w_state_nxt = IDLE;
      w_up_nxt    = 10'(SPAWN_UP);
      w_left_nxt  = 10'(SPAWN_LEFT);
      w_dir_nxt   = c_dir_right;
      w_vis_nxt   = 1'b1;
      w_lives_nxt = 2'(LIVES);
      w_go_nxt    = 1'b0;
      w_hold_nxt  = '0;
    end else begin
      case (r_state)
        IDLE: w_state_nxt = PLAY;
        PLAY: begin
          if (w_hit) begin
            if (lives > 2'd1) begin
              w_state_nxt = HIT;
              w_lives_nxt = lives - 2'd1;
              w_up_nxt    = 10'(SPAWN_UP);
              w_left_nxt  = 10'(SPAWN_LEFT);
              w_dir_nxt   = c_dir_right;
              w_vis_nxt   = 1'b1;
              w_hold_nxt  = HOLD_W'(HIT_TICKS);
            end else begin
              w_state_nxt = DEAD;
              w_lives_nxt = 2'd0;
              w_go_nxt    = 1'b1;
              w_vis_nxt   = 1'b1;
            end
          end else if (w_tick) begin
            w_up_nxt   = w_up_moved;
            w_left_nxt = w_left_moved;
            w_dir_nxt  = w_dir_moved;
          end
        end
        HIT: begin
          if (w_tick) begin
            if (r_hold <= HOLD_W'(1)) begin
              w_state_nxt = PLAY;
              w_hold_nxt  = '0;
              w_vis_nxt   = 1'b1;
            end else begin
              w_hold_nxt = r_hold - HOLD_W'(1);
              w_vis_nxt  = ~visible;
            end
          end
        end
        DEAD: w_state_nxt = DEAD;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      people_up   <= 10'(SPAWN_UP);
      people_left <= 10'(SPAWN_LEFT);
      dir         <= c_dir_right;
      visible     <= 1'b1;
      lives       <= 2'(LIVES);
      game_over   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold      <= w_hold_nxt;
      people_up   <= w_up_nxt;
      people_left <= w_left_nxt;
      dir         <= w_dir_nxt;
      visible     <= w_vis_nxt;
      lives       <= w_lives_nxt;
      game_over   <= w_go_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_people_move_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_people_move_control
//  Purpose  : Vector-table bench for people_move_control with TICK_DIV=4.
//  Revision : 1.0  initial release
// ============================================================================
module tb_people_move_control;

  logic       clk, rst_n;
  logic [2:0] stage_state;
  logic       key_up, key_down, key_left, key_right, fail;
  logic [9:0] people_up, people_left;
  logic [1:0] dir, lives;
  logic       visible, game_over;

  people_move_control #(.TICK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .stage_state(stage_state),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .fail(fail), .people_up(people_up), .people_left(people_left), .dir(dir),
    .visible(visible), .lives(lives), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef PEOPLE_DIAG_EN
  localparam int EXP_DIAG_LEFT = 103;
`else
  localparam int EXP_DIAG_LEFT = 100;
`endif

  localparam logic [3:0] K_NO = 4'b0000;
  localparam logic [3:0] K_UP = 4'b1000;
  localparam logic [3:0] K_DN = 4'b0100;
  localparam logic [3:0] K_LF = 4'b0010;
  localparam logic [3:0] K_RT = 4'b0001;

  typedef struct {
    logic [2:0] stage;
    logic [3:0] keys;
    logic       fail;
    int         n;
    int         e_up, e_left, e_dir, e_vis, e_lives, e_go;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(input int stg, input logic [3:0] k, input logic f, input int n,
                     input int eu, input int el, input int ed, input int ev,
                     input int elv, input int eg);
    vec_t v;
    v.stage = 3'(stg); v.keys = k; v.fail = f; v.n = n;
    v.e_up = eu; v.e_left = el; v.e_dir = ed; v.e_vis = ev; v.e_lives = elv; v.e_go = eg;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s (step %0d): got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input vec_t e);
    chk("people_up",   idx, int'(people_up),   e.e_up);
    chk("people_left", idx, int'(people_left), e.e_left);
    chk("dir",         idx, int'(dir),         e.e_dir);
    chk("visible",     idx, int'(visible),     e.e_vis);
    chk("lives",       idx, int'(lives),       e.e_lives);
    chk("game_over",   idx, int'(game_over),   e.e_go);
  endtask

  initial begin
    vec_t e;
    stage_state = 3'd0; {key_up, key_down, key_left, key_right} = K_NO; fail = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    e.e_up = 330; e.e_left = 100; e.e_dir = 1; e.e_vis = 1; e.e_lives = 3; e.e_go = 0;
    chk_all(-1, e);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // stage, keys, fail, clocks -> up, left, dir, visible, lives, game_over
    add(0, K_NO, 0, 2,     330, 100, 1, 1, 3, 0);
    add(5, K_NO, 0, 1,     330, 100, 1, 1, 3, 0);
    add(5, K_UP, 0, 2,     330, 100, 1, 1, 3, 0);
    add(5, K_UP, 0, 1,     327, 100, 2, 1, 3, 0);
    add(5, K_UP, 0, 4,     324, 100, 2, 1, 3, 0);
    add(5, K_UP, 0, 4,     321, 100, 2, 1, 3, 0);
    add(5, K_UP, 0, 340,    66, 100, 2, 1, 3, 0);
    add(5, K_UP, 0, 4,      65, 100, 2, 1, 3, 0);
    add(5, K_UP, 0, 8,      65, 100, 2, 1, 3, 0);
    add(5, K_LF, 0, 76,     65,  43, 0, 1, 3, 0);
    add(5, K_LF, 0, 4,      65,  40, 0, 1, 3, 0);
    add(5, K_LF, 0, 8,      65,  40, 0, 1, 3, 0);
    add(5, K_UP|K_DN, 0, 8, 65,  40, 0, 1, 3, 0);
    add(5, K_LF|K_RT, 0, 4, 65,  40, 0, 1, 3, 0);
    add(5, K_DN, 0, 4,      68,  40, 3, 1, 3, 0);
    add(5, K_RT, 0, 4,      68,  43, 1, 1, 3, 0);
    add(5, K_DN|K_LF|K_RT, 0, 4, 71, 43, 3, 1, 3, 0);
    add(5, K_UP|K_DN|K_RT, 0, 4, 71, 46, 1, 1, 3, 0);
    add(5, K_DN, 0, 436,   398,  46, 3, 1, 3, 0);
    add(5, K_DN, 0, 4,     400,  46, 3, 1, 3, 0);
    add(5, K_DN, 0, 4,     400,  46, 3, 1, 3, 0);
    add(5, K_RT, 0, 684,   400, 559, 1, 1, 3, 0);
    add(5, K_RT, 0, 4,     400, 560, 1, 1, 3, 0);
    add(5, K_RT, 0, 4,     400, 560, 1, 1, 3, 0);
    // first hit: respawn, blink for ten ticks with key_up held and ignored
    add(5, K_NO, 1, 1,     330, 100, 1, 1, 2, 0);
    add(5, K_UP, 1, 3,     330, 100, 1, 0, 2, 0);
    add(5, K_UP, 1, 4,     330, 100, 1, 1, 2, 0);
    add(5, K_UP, 1, 4,     330, 100, 1, 0, 2, 0);
    add(5, K_UP, 1, 24,    330, 100, 1, 0, 2, 0);
    add(5, K_UP, 1, 4,     330, 100, 1, 1, 2, 0);
    add(5, K_UP|K_RT, 0, 4, 327, EXP_DIAG_LEFT, 2, 1, 2, 0);
    // second hit, then the last life
    add(5, K_NO, 1, 1,     330, 100, 1, 1, 1, 0);
    add(5, K_NO, 1, 3,     330, 100, 1, 0, 1, 0);
    add(5, K_NO, 1, 36,    330, 100, 1, 1, 1, 0);
    add(5, K_NO, 0, 4,     330, 100, 1, 1, 1, 0);
    add(5, K_LF, 1, 1,     330, 100, 1, 1, 0, 1);
    add(5, K_LF, 1, 7,     330, 100, 1, 1, 0, 1);
    add(2, K_NO, 1, 1,     330, 100, 1, 1, 3, 0);
    add(2, K_NO, 0, 2,     330, 100, 1, 1, 3, 0);
    add(5, K_NO, 0, 1,     330, 100, 1, 1, 3, 0);
    add(5, K_NO, 0, 3,     330, 100, 1, 1, 3, 0);
    // fail rising on the same cycle the stage is left must not cost a life
    add(2, K_NO, 1, 1,     330, 100, 1, 1, 3, 0);
    add(5, K_NO, 1, 1,     330, 100, 1, 1, 3, 0);
    add(5, K_UP, 0, 3,     327, 100, 2, 1, 3, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      stage_state = vecs[i].stage;
      {key_up, key_down, key_left, key_right} = vecs[i].keys;
      fail = vecs[i].fail;
      exp_q.push_back(vecs[i]);
      repeat (vecs[i].n - 1) @(posedge clk);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", i, 0, 1);
      end else begin
        e = exp_q.pop_front();
        chk_all(i, e);
      end
    end

    // asynchronous reset in the middle of a move, checked before any clock edge
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    e.e_up = 330; e.e_left = 100; e.e_dir = 1; e.e_vis = 1; e.e_lives = 3; e.e_go = 0;
    chk_all(999, e);
    @(negedge clk);
    rst_n = 1'b1;
    {key_up, key_down, key_left, key_right} = K_NO;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
